// File: rtl/adder_cla_pkg.sv
// rtl/adder_cla_pkg.sv - shared constants, types and group g/p helper for the pipelined CLA adder
//
// Purpose : GROUP_W (lookahead group size) and the g4/p4 pair typedef used by
//           adder_cla_pipe and cla_group4, plus a function computing the
//           group generate/propagate of a 4-bit slice.
// Ports   : none (package).
package adder_cla_pkg;

  localparam int GROUP_W = 4;

  typedef struct packed {
    logic g4;
    logic p4;
  } grp_gp_t;

  // p uses OR-propagate (x|y); valid for carry lookahead, not for sum bits.
  function automatic grp_gp_t group_gp(input logic [GROUP_W-1:0] a,
                                       input logic [GROUP_W-1:0] b);
    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] p;
    grp_gp_t            r;
    g    = a & b;
    p    = a | b;
    r.g4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    r.p4 = &p;
    return r;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// rtl/cla_group4.sv - 4-bit carry-lookahead group: internal carries, sum bits, group g4/p4
//
// Purpose : one lookahead group; all internal carries are flat sum-of-products
//           of the group carry-in, so nothing ripples inside the group.
// Ports   : a_i, b_i - 4-bit operand slices (b already inverted for subtract)
//           c_i      - group carry-in from the lookahead unit
//           s_o      - 4 sum bits
//           g4_o     - group generate
//           p4_o     - group propagate
module cla_group4
  import adder_cla_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       g4_o,
  output logic       p4_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;
  grp_gp_t    gp;

  assign g = a_i & b_i;
  assign p = a_i | b_i;

  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);

  assign s_o = a_i ^ b_i ^ c;

  assign gp   = group_gp(a_i, b_i);
  assign g4_o = gp.g4;
  assign p4_o = gp.p4;

endmodule

// File: rtl/adder_cla_pipe.sv
// rtl/adder_cla_pipe.sv - 2-stage pipelined carry-lookahead adder/subtractor with valid/ready
//
// Purpose : stage 1 registers effective operands, effective carry and per-group
//           g4/p4; stage 2 resolves group carries by lookahead, forms sum/c_out
//           and registers them. Both stages use valid/ready handshakes with
//           bubble collapse.
// Macro   : ADDER_CLA_OVF_EN - when defined, ovf is the registered signed
//           overflow flag; otherwise ovf is tied to 0.
// Ports   : clk, rst_n (async, active-low)
//           in_valid/in_ready, x, y, c_in, op_sub - operand side
//           out_valid/out_ready, sum, c_out, ovf  - result side
module adder_cla_pipe
  import adder_cla_pkg::*;
#(
  parameter int WIDTH = 16
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NG = WIDTH / GROUP_W;

  // Stage 1 state
  logic                v1_q;
  logic [WIDTH-1:0]    a1_q, a1_d;
  logic [WIDTH-1:0]    b1_q, b1_d;
  logic                c1_q, c1_d;
  grp_gp_t [NG-1:0]    gp1_q, gp1_d;

  // Stage 2 state
  logic                v2_q;
  logic [WIDTH-1:0]    sum_q, sum_d;
  logic                cout_q, cout_d;

  logic                ready1;
  logic                ready2;
  logic [NG:0]         cg;
  logic [NG-1:0]       g4_unused;
  logic [NG-1:0]       p4_unused;

  assign ready2   = !v2_q | out_ready;
  assign ready1   = !v1_q | ready2;
  assign in_ready = ready1;

  // Subtract is x + ~y + 1; c_in only matters when adding.
  always_comb begin
    a1_d = x;
    b1_d = op_sub ? ~y : y;
    c1_d = op_sub ? 1'b1 : c_in;
    for (int i = 0; i < NG; i++) begin
      gp1_d[i] = group_gp(a1_d[i*GROUP_W +: GROUP_W], b1_d[i*GROUP_W +: GROUP_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      a1_q  <= '0;
      b1_q  <= '0;
      c1_q  <= 1'b0;
      gp1_q <= '0;
    end else if (ready1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        a1_q  <= a1_d;
        b1_q  <= b1_d;
        c1_q  <= c1_d;
        gp1_q <= gp1_d;
      end
    end
  end

  // Each group carry is an independent flat product-sum over lower groups'
  // g4/p4 and the stage carry; no group carry depends on another group carry.
  always_comb begin : lookahead
    logic acc;
    logic pp;
    cg    = '0;
    acc   = 1'b0;
    pp    = 1'b1;
    cg[0] = c1_q;
    for (int k = 1; k <= NG; k++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        acc = acc | (pp & gp1_q[j].g4);
        pp  = pp & gp1_q[j].p4;
      end
      cg[k] = acc | (pp & c1_q);
    end
  end

  for (genvar i = 0; i < NG; i++) begin : g_grp
    cla_group4 u_grp (
      .a_i  (a1_q[i*GROUP_W +: GROUP_W]),
      .b_i  (b1_q[i*GROUP_W +: GROUP_W]),
      .c_i  (cg[i]),
      .s_o  (sum_d[i*GROUP_W +: GROUP_W]),
      .g4_o (g4_unused[i]),
      .p4_o (p4_unused[i])
    );
  end

  assign cout_d = cg[NG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (ready2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

  assign out_valid = v2_q;
  assign sum       = sum_q;
  assign c_out     = cout_q;

`ifdef ADDER_CLA_OVF_EN
  logic ovf_q;
  logic ovf_d;
  logic c_msb;

  // Carry into the MSB recovered from the MSB sum bit.
  assign c_msb = a1_q[WIDTH-1] ^ b1_q[WIDTH-1] ^ sum_d[WIDTH-1];
  assign ovf_d = c_msb ^ cout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (ready2 && v1_q) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_adder_cla_pipe.sv
// tb/tb_adder_cla_pipe.sv - self-checking bench for adder_cla_pipe (WIDTH=16)
module tb_adder_cla_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         c_in = 1'b0;
  logic         op_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           age;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  adder_cla_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .c_in      (c_in),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  // Reference: plain integer arithmetic. Returns {ovf, c_out, sum}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic ci, input logic sub);
    logic [W:0] r;
    int         s;
    logic       ov;
    if (sub) begin
      r[W-1:0] = a - b;
      r[W]     = (a >= b);
      s        = int'($signed(a)) - int'($signed(b));
    end else begin
      r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      s = int'($signed(a)) + int'($signed(b)) + (ci ? 1 : 0);
    end
    ov = (s > 32767) || (s < -32768);
`ifndef ADDER_CLA_OVF_EN
    ov = 1'b0;
`endif
    return {ov, r};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (sum !== '0) begin n_err++; $display("FAIL rst_sum: got %h want 0000", sum); end
    n_cmp++; if (c_out !== 1'b0) begin n_err++; $display("FAIL rst_c_out: got %b want 0", c_out); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_out_valid: got %b want 0", out_valid); end
    tick();
  endtask

  task automatic test_directed;
    logic [W-1:0] tx [4];
    logic [W-1:0] ty [4];
    logic         tc [4];
    logic         ts [4];
    logic [W-1:0] es [4];
    logic         ec [4];
    logic         eo [4];
    tx = '{16'h0001, 16'hFFFF, 16'h0005, 16'h7FFF};
    ty = '{16'h0001, 16'h0000, 16'h0007, 16'h0001};
    tc = '{1'b0, 1'b1, 1'b1, 1'b0};
    ts = '{1'b0, 1'b0, 1'b1, 1'b0};
    es = '{16'h0002, 16'h0000, 16'hFFFE, 16'h8000};
    ec = '{1'b0, 1'b1, 1'b0, 1'b0};
    eo = '{1'b0, 1'b0, 1'b0, 1'b0};
`ifdef ADDER_CLA_OVF_EN
    eo[3] = 1'b1;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; x = tx[i]; y = ty[i]; c_in = tc[i]; op_sub = ts[i];
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL dir_in_ready[%0d]: got %b want 1", i, in_ready); end
      tick();  // accepted at edge N
      in_valid = 1'b0; x = 16'h1234; y = 16'h4321; c_in = 1'b1; op_sub = 1'b1;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir_early_valid[%0d]: got %b want 0", i, out_valid); end
      tick();  // edge N+1: result presented, taken at edge N+2
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL dir_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (sum !== es[i]) begin n_err++; $display("FAIL dir_sum[%0d]: got %h want %h", i, sum, es[i]); end
      n_cmp++; if (c_out !== ec[i]) begin n_err++; $display("FAIL dir_c_out[%0d]: got %b want %b", i, c_out, ec[i]); end
      n_cmp++; if (ovf !== eo[i]) begin n_err++; $display("FAIL dir_ovf[%0d]: got %b want %b", i, ovf, eo[i]); end
      tick();
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir_dup[%0d]: got %b want 0", i, out_valid); end
      tick();
    end
  endtask

  task automatic test_stall;
    logic [W-1:0] ta [3];
    logic [W-1:0] tb [3];
    logic         tc [3];
    logic         ts [3];
    logic [W+1:0] e  [3];
    for (int k = 0; k < 3; k++) begin
      ta[k] = W'($urandom); tb[k] = W'($urandom);
      tc[k] = 1'($urandom); ts[k] = 1'($urandom);
      e[k]  = ref_op(ta[k], tb[k], tc[k], ts[k]);
    end
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; x = ta[k]; y = tb[k]; c_in = tc[k]; op_sub = ts[k];
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_accept[%0d]: got %b want 1", k, in_ready); end
      tick();
    end
    x = ta[2]; y = tb[2]; c_in = tc[2]; op_sub = ts[2];
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %b want 0", h, in_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", h, out_valid); end
      n_cmp++; if ({ovf, c_out, sum} !== e[0]) begin n_err++; $display("FAIL stall_hold[%0d]: got %h want %h", h, {ovf, c_out, sum}, e[0]); end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
    for (int k = 0; k < 3; k++) begin
      if (k == 1) @(negedge clk);
      if (k == 2) @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d]: got %b want 1", k, out_valid); end
      n_cmp++; if ({ovf, c_out, sum} !== e[k]) begin n_err++; $display("FAIL drain_res[%0d]: got %h want %h", k, {ovf, c_out, sum}, e[k]); end
      tick();
      in_valid = 1'b0;
    end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", out_valid); end
    tick();
  endtask

  task automatic test_reset_flight;
    out_ready = 1'b1;
    in_valid = 1'b1; x = W'($urandom); y = W'($urandom); c_in = 1'b0; op_sub = 1'b0;
    tick();
    x = W'($urandom); y = W'($urandom);
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flight_valid: got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flight_rst_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flight_rst_ready: got %b want 1", in_ready); end
    n_cmp++; if (sum !== '0) begin n_err++; $display("FAIL flight_rst_sum: got %h want 0000", sum); end
    tick();
    rst_n = 1'b1;
    for (int h = 0; h < 4; h++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flight_stale[%0d]: got %b want 0", h, out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flight_ready[%0d]: got %b want 1", h, in_ready); end
      tick();
    end
  endtask

  // Model: queue of outstanding results, each aged in edges since acceptance.
  // A result is presented once it is at the head and at least one edge old;
  // the pipeline holds two, so input is refused only when full and stalled.
  task automatic test_random;
    logic         exp_ready;
    logic         exp_valid;
    logic         acc_in;
    logic         acc_out;
    logic [W+1:0] r;
    exp_t         e;
    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc < 590) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      x = W'($urandom); y = W'($urandom); c_in = 1'($urandom); op_sub = 1'($urandom);
      if (cyc % 37 == 0) begin x = 16'h7FFF; y = 16'h8000; end
      @(negedge clk);
      exp_ready = (q.size() < 2) || out_ready;
      exp_valid = (q.size() > 0) && (q[0].age >= 1);
      n_cmp++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", cyc, in_ready, exp_ready); end
      n_cmp++; if (out_valid !== exp_valid) begin n_err++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", cyc, out_valid, exp_valid); end
      if (exp_valid) begin
        n_cmp++;
        if ({ovf, c_out, sum} !== {q[0].ov, q[0].co, q[0].s}) begin
          n_err++;
          $display("FAIL rnd_result[%0d]: got %h want %h", cyc, {ovf, c_out, sum}, {q[0].ov, q[0].co, q[0].s});
        end
      end
      acc_in  = in_valid && exp_ready;
      acc_out = exp_valid && out_ready;
      r = ref_op(x, y, c_in, op_sub);
      @(posedge clk);
      if (acc_out) void'(q.pop_front());
      for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
      if (acc_in) begin
        e.s = r[W-1:0]; e.co = r[W]; e.ov = r[W+1]; e.age = 0;
        q.push_back(e);
      end
      #1;
    end
    n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL rnd_drain: got %0d left want 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_flight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
